sa_ram_rd_stream_64x64: RTL and testbench

Read-side controller for the 64x64 read/write-split SA RAM macro (registered read address, one-cycle read latency). Takes a burst command (base address and length) and drives the RAM read port. Returns the words as a valid/ready stream with out_last on the final word. A 2-entry skid FIFO absorbs the RAM latency, so the stream runs at one word per cycle under backpressure without losing data.

---
 rtl/sa_ram_rd_stream_64x64.sv | 139 +++++++++++++
 tb/tb_sa_ram_rd_stream_64x64.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ram_rd_stream_64x64.sv
// Burst read controller for the 64x64 SA RAM: issues reads, returns words as a valid/ready stream.
// Optional popped-word counter output enabled by SA_RAM_RD_STREAM_CNT_EN.
module sa_ram_rd_stream_64x64 #(
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
`ifdef SA_RAM_RD_STREAM_CNT_EN
  ,
  output logic [15:0]   word_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [AW:0]   RemOne  = 1;
  localparam logic [AW-1:0] AddrOne = 1;
  localparam logic [2:0]    Credits = 3'(FIFO_DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW:0]     rem_q, rem_d;
  logic            inflight_q, last_tag_q;
  logic [DW-1:0]   fifo_data_q [FIFO_DEPTH];
  logic            fifo_last_q [FIFO_DEPTH];
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      count_q;
  logic            pop, push, issue_last;
  logic [2:0]      credit;

  assign out_valid  = (count_q != 2'd0);
  assign pop        = out_valid && out_ready;
  assign push       = inflight_q;
  assign out_data   = fifo_data_q[rd_ptr_q];
  assign out_last   = out_valid && fifo_last_q[rd_ptr_q];
  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign ram_ra     = addr_q;
  assign issue_last = (rem_q == RemOne);

  // Occupied plus in-flight words, counting a same-cycle pop as already freed.
  assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign ram_re = (state_q == StRun) && (credit < Credits);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_base;
          rem_d   = {1'b0, cmd_len} + RemOne;
          state_d = StRun;
        end
      end
      StRun: begin
        if (ram_re) begin
          addr_d = addr_q + AddrOne;
          rem_d  = rem_q - RemOne;
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= ram_re;
      last_tag_q <= ram_re && issue_last;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_dout;
        fifo_last_q[wr_ptr_q] <= last_tag_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SA_RAM_RD_STREAM_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      word_cnt_q <= 16'd0;
    end else if (pop && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_sa_ram_rd_stream_64x64.sv
// Scoreboard bench for sa_ram_rd_stream_64x64 paired with a preloaded RAM model M[i]={8{i}}.
module tb_sa_ram_rd_stream_64x64;

  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef SA_RAM_RD_STREAM_CNT_EN
  logic [15:0]   word_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int pops_total = 0;

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] ra_q[$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  sa_ram_rd_stream_64x64 #(.AW(AW), .DW(DW), .FIFO_DEPTH(2)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_base       (cmd_base),
    .cmd_len        (cmd_len),
    .ram_ra         (ram_ra),
    .ram_re         (ram_re),
    .ram_dout       (ram_dout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
`ifdef SA_RAM_RD_STREAM_CNT_EN
    ,
    .word_cnt       (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [7:0] b;
    b = {2'b00, a};
    return {8{b}};
  endfunction

  // RAM model: registered read, data valid the cycle after ram_re.
  always @(posedge clk) begin
    if (ram_re) ram_dout <= word_of(ram_ra);
  end

  // Output scoreboard, address checker, stall stability and FIFO occupancy monitor.
  always @(negedge clk) begin
    logic [DW:0]   e;
    logic [AW-1:0] ea;
    if (ram_re) begin
      checks++;
      if (ra_q.size() == 0) begin
        failures++;
        $display("FAIL ram_ra_unexpected: got %0d, no issue expected", ram_ra);
      end else begin
        ea = ra_q.pop_front();
        if (ram_ra !== ea) begin
          failures++;
          $display("FAIL ram_ra: got %0d expected %0d", ram_ra, ea);
        end
      end
    end
    if (prev_stall && rstn) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
        failures++;
        $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      pops_total++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected: got %h last=%b, none expected", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e[DW-1:0] || out_last !== e[DW]) begin
          failures++;
          $display("FAIL word: got %h last=%b expected %h last=%b",
                   out_data, out_last, e[DW-1:0], e[DW]);
        end
      end
    end
    checks++;
    if (dut.count_q > 2'd2 || (dut.inflight_q && dut.count_q == 2'd2 && !(out_valid && out_ready)))
    begin
      failures++;
      $display("FAIL fifo_overflow: got count=%0d inflight=%b, expected push never into full",
               dut.count_q, dut.inflight_q);
    end
    prev_stall = rstn && out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic send_cmd(input logic [AW-1:0] base, input logic [AW-1:0] len);
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    for (int i = 0; i <= int'(len); i++) begin
      a = base + AW'(i);
      exp_q.push_back({(i == int'(len)), word_of(a)});
      ra_q.push_back(a);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_before_cmd: got %b expected 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && cmd_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL %s_timeout: got %0d words left busy=%b, expected 0 words idle",
               name, exp_q.size(), busy);
    end
`ifdef SA_RAM_RD_STREAM_CNT_EN
    checks++;
    if (word_cnt !== 16'(pops_total)) begin
      failures++;
      $display("FAIL %s_word_cnt: got %0d expected %0d", name, word_cnt, pops_total);
    end
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || ram_re !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_data !== '0 || busy !== 1'b0 || ram_ra !== '0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b re=%b ra=%0d v=%b l=%b d=%h busy=%b expected 1 0 0 0 0 0 0",
               cmd_ready, ram_re, ram_ra, out_valid, out_last, out_data, busy);
    end
  endtask

  task automatic test_basic();
    send_cmd(6'd5, 6'd3);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (ram_re !== 1'b1 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL basic_first_issue: got re=%b v=%b expected re=1 v=0", ram_re, out_valid);
        end
      end else if (k == 1 || k == 2) begin
        checks++;
        if (out_valid !== (k == 2)) begin
          failures++;
          $display("FAIL basic_latency_k%0d: got v=%b expected %b", k, out_valid, k == 2);
        end
      end else if (k >= 3 && k <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_last !== (k == 5)) begin
          failures++;
          $display("FAIL basic_stream_k%0d: got v=%b l=%b expected v=1 l=%b",
                   k, out_valid, out_last, k == 5);
        end
      end else begin
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL basic_done: got rdy=%b busy=%b v=%b expected 1 0 0",
                   cmd_ready, busy, out_valid);
        end
      end
    end
    wait_idle("basic");
  endtask

  task automatic test_wrap();
    send_cmd(6'd62, 6'd3);
    wait_idle("wrap");
  endtask

  task automatic test_backpressure();
    int n = 0;
    send_cmd(6'd0, 6'd7);
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      out_ready = (n % 4 == 0) || (n % 4 == 3);
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_full_burst();
    int k = 0;
    logic seen = 1'b0;
    send_cmd(6'd40, 6'd63);
    while (!seen && k < 200) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) seen = 1'b1;
      else k++;
    end
    checks++;
    if (k != 65) begin
      failures++;
      $display("FAIL full_burst_cycles: got %0d expected 65", k);
    end
    wait_idle("full_burst");
  endtask

  task automatic test_mid_reset();
    int pops = 0;
    int n = 0;
    send_cmd(6'd10, 6'd15);
    while (pops < 3 && n < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) pops++;
      n++;
    end
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    ra_q.delete();
    pops_total = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ram_re !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_state: got v=%b re=%b busy=%b rdy=%b expected 0 0 0 1",
               out_valid, ram_re, busy, cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_stale: got v=%b expected 0", out_valid);
      end
    end
    send_cmd(6'd0, 6'd0);
    wait_idle("after_reset");
  endtask

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_full_burst();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
